maxpool2x2_stream: RTL and testbench
====================================

// Module: maxpool2x2_stream
// PURPOSE
//  Streaming 2x2/stride-2 max-pool stage that consumes the rectified activation stream
//  (one signed pixel per beat, raster order) produced after each convolution feature map.
//  Emits one pooled pixel per 2x2 window toward the next conv or dense stage.
//  Uses a half-width line buffer; valid/ready handshake on both sides.
// PARAMETERS
//  W      9   pixel width, signed two's complement, same on input and output
//  IMG_W  26  input feature-map width in pixels; must be even (elaboration error otherwise)
//  IMG_H  26  input feature-map height in rows; must be even (elaboration error otherwise)
// PORTS
//  clk        in   1        single clock; all logic on rising edge
//  rst        in   1        synchronous, active-high reset
//  in_data    in   W        signed input pixel
//  in_valid   in   1        in_data valid
//  in_ready   out  1        block accepts in_data this cycle
//  out_data   out  W        signed pooled pixel
//  out_valid  out  1        out_data valid
//  out_ready  in   1        downstream accepts out_data
//  out_last   out  1        qualifies the final pooled pixel of a frame (out_valid high)
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_last=0, col/row counters=0, pair register cleared;
//    line buffer not reset (always written before read). in_ready is 1 after reset.
//  - Beat accepted when in_valid && in_ready. in_ready = !out_valid || out_ready.
//  - Counters: col 0..IMG_W-1, row 0..IMG_H-1; col wraps to 0 and row increments on
//    col==IMG_W-1; row wraps to 0 after the last pixel of the frame, so frames are back-to-back.
//  - Even col: pixel held in pair register. Odd col: h = max(pair, pixel) (signed compare).
//  - Even row, odd col: lbuf[col>>1] <= h. Odd row, odd col: out_data <= max(lbuf[col>>1], h),
//    out_valid <= 1, out_last <= (row==IMG_H-1 && col==IMG_W-1).
//  - Latency: out_valid rises the cycle after the 4th pixel of a window is accepted.
//  - Output held stable while out_valid && !out_ready; out_valid clears on out_ready unless a
//    new window completes in the same cycle (then data replaced, out_valid stays 1).
//  - Ties: equal values give that value; max(-256, -256) = -256 (no saturation needed).
//  - Back-pressure with full throughput: 1 pixel/cycle in, 1 pooled per 4 input beats.
//  - Reset mid-frame: pending output dropped, counters restart at (0,0); next accepted pixel
//    is treated as frame origin.
// CONFIGURATION
//  FUSED_RELU_EN defined: input pixel clamped (in_data<0 -> 0) before pairing, so the block
//    also performs rectification; out_data always >= 0.
//  FUSED_RELU_EN undefined: pure signed max; negative outputs possible.
// STRUCTURE
//  - Shared package cnn_pkg: PIX_W default, fmap dimension constants, signed max function.
//  - Sub-module pool_linebuf: IMG_W/2 x W single-port-write/read buffer indexed by col>>1.
//  - Top holds counters, pair register, output register and handshake.
// TESTING
//  - 4x4 frame (IMG_W=IMG_H=4), ramp 0..15, out_ready=1 -> outputs 5,7,13,15; last on 15.
//  - Negatives: window {-3,-7,-1,-9} -> -1 without FUSED_RELU_EN, 0 with it.
//  - out_ready low 5 cycles while out_valid -> in_ready low, out_data stable, no pixel loss.
//  - Two back-to-back 26x26 frames, random in_valid -> 169 outputs each, out_last twice.
//  - rst asserted after 7 pixels -> out_valid 0 next cycle; fresh 4x4 ramp gives 5,7,13,15.
//  - Extremes: window {255,-256,255,-256} -> 255; all -256 -> -256 (W=9).

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN definitions: default pixel width, feature-map dimensions, beat classification
// and a signed max helper used by the pooling stages.
package cnn_pkg;

    localparam int PIX_W  = 9;
    localparam int FMAP_W = 26;
    localparam int FMAP_H = 26;

    // Wide signed carrier so one max helper serves any pixel width up to 32 bits.
    localparam int MAX_W  = 32;
    typedef logic signed [MAX_W-1:0] wide_pix_t;

    typedef enum logic [1:0] {
        BEAT_IDLE  = 2'd0,
        BEAT_PAIR  = 2'd1,
        BEAT_STORE = 2'd2,
        BEAT_EMIT  = 2'd3
    } beat_kind_t;

    function automatic wide_pix_t smax(input wide_pix_t a, input wide_pix_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Half-width line buffer: one horizontal-max entry per pooling window column.
// Shared address for write and read; contents are never reset because every entry is written before it is read.
module pool_linebuf
    import cnn_pkg::*;
#(
    parameter int W     = PIX_W,
    parameter int DEPTH = FMAP_W / 2,
    parameter int AW    = 4
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [AW-1:0]       addr,
    input  logic signed [W-1:0] wr_data,
    output logic signed [W-1:0] rd_data
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[addr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max-pool with valid/ready on both sides and a half-width line buffer.
// Build macro FUSED_RELU_EN: when defined, negative input pixels are clamped to zero before pooling.
module maxpool2x2_stream
    import cnn_pkg::*;
#(
    parameter int W     = PIX_W,
    parameter int IMG_W = FMAP_W,
    parameter int IMG_H = FMAP_H
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last
);

    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int LB_DEPTH = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
    localparam int AW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    generate
        if (((IMG_W % 2) != 0) || (IMG_W < 2)) begin : g_bad_img_w
            $error("maxpool2x2_stream: IMG_W must be even and at least 2");
        end
        if (((IMG_H % 2) != 0) || (IMG_H < 2)) begin : g_bad_img_h
            $error("maxpool2x2_stream: IMG_H must be even and at least 2");
        end
    endgenerate

    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic signed [W-1:0] pair_q, pair_d;
    logic signed [W-1:0] out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;

    logic                accept;
    logic                col_last;
    logic                row_last;
    logic signed [W-1:0] pix;
    logic signed [W-1:0] h_max;
    logic signed [W-1:0] lb_rd_data;
    logic [AW-1:0]       lb_addr;
    logic                lb_wr_en;
    beat_kind_t          beat;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign lb_addr  = AW'(col_q >> 1);

`ifdef FUSED_RELU_EN
    assign pix = in_data[W-1] ? '0 : in_data;
`else
    assign pix = in_data;
`endif

    assign h_max = W'(smax(wide_pix_t'(pair_q), wide_pix_t'(pix)));

    // Even columns load the pair register; odd columns either park the row max or finish a window.
    always_comb begin
        beat = BEAT_IDLE;
        if (accept) begin
            if (!col_q[0]) begin
                beat = BEAT_PAIR;
            end else if (!row_q[0]) begin
                beat = BEAT_STORE;
            end else begin
                beat = BEAT_EMIT;
            end
        end
    end

    assign lb_wr_en = (beat == BEAT_STORE);

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        pair_d      = pair_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (accept) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // A window finishing in the same cycle as a handoff replaces the data and keeps valid high.
        case (beat)
            BEAT_PAIR: begin
                pair_d = pix;
            end
            BEAT_EMIT: begin
                out_data_d  = W'(smax(wide_pix_t'(lb_rd_data), wide_pix_t'(h_max)));
                out_valid_d = 1'b1;
                out_last_d  = row_last && col_last;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            pair_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pair_q      <= pair_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    pool_linebuf #(
        .W     (W),
        .DEPTH (LB_DEPTH),
        .AW    (AW)
    ) u_linebuf (
        .clk     (clk),
        .wr_en   (lb_wr_en),
        .addr    (lb_addr),
        .wr_data (h_max),
        .rd_data (lb_rd_data)
    );

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream: a 4x4 instance for directed/random frames and a
// 26x26 instance for back-to-back random frames, checked against a window-level reference model.
module tb_maxpool2x2_stream;

`ifdef FUSED_RELU_EN
    localparam int NEG_EXP = 0;
    localparam int MIN_EXP = 0;
`else
    localparam int NEG_EXP = -1;
    localparam int MIN_EXP = -256;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic signed [8:0] a_in_data, a_out_data;
    logic              b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic signed [8:0] b_in_data, b_out_data;

    int checks   = 0;
    int failures = 0;

    int a_got_d[$];
    bit a_got_l[$];
    int b_got_d[$];
    bit b_got_l[$];
    int exp_d[$];
    bit exp_l[$];

    maxpool2x2_stream #(.W(9), .IMG_W(4), .IMG_H(4)) dut_a (
        .clk(clk), .rst(a_rst),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_last(a_out_last)
    );

    maxpool2x2_stream #(.W(9), .IMG_W(26), .IMG_H(26)) dut_b (
        .clk(clk), .rst(b_rst),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_last(b_out_last)
    );

    // Record every completed output handshake; values at the falling edge match the next rising edge.
    always @(negedge clk) begin
        if (!a_rst && a_out_valid && a_out_ready) begin
            a_got_d.push_back(int'(a_out_data));
            a_got_l.push_back(a_out_last);
        end
        if (!b_rst && b_out_valid && b_out_ready) begin
            b_got_d.push_back(int'(b_out_data));
            b_got_l.push_back(b_out_last);
        end
    end

    // Reference: pooled value of one 2x2 window, with optional rectification of each pixel.
    function automatic int ref_win(input int p0, input int p1, input int p2, input int p3);
        int v[4];
        int m;
        int x;
        v = '{p0, p1, p2, p3};
        m = -100000;
        for (int i = 0; i < 4; i++) begin
            x = v[i];
`ifdef FUSED_RELU_EN
            if (x < 0) x = 0;
`endif
            if (x > m) m = x;
        end
        return m;
    endfunction

    // Appends the expected pooled stream of one frame stored raster-order at pix[base...].
    function automatic void build_expected(input int pix[$], input int w, input int h, input int base);
        int tl;
        for (int r = 0; r < h / 2; r++) begin
            for (int c = 0; c < w / 2; c++) begin
                tl = base + 2 * r * w + 2 * c;
                exp_d.push_back(ref_win(pix[tl], pix[tl + 1], pix[tl + w], pix[tl + w + 1]));
                exp_l.push_back((r == h / 2 - 1) && (c == w / 2 - 1));
            end
        end
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Streams pix into instance sel (0 = 4x4, 1 = 26x26) under a cycle budget.
    task automatic drive_frame(input int sel, input int pix[$], input bit rand_valid, input bit rand_ready);
        int idx;
        int cyc;
        int v;
        bit vld;
        bit acc;
        idx = 0;
        cyc = 0;
        while (idx < pix.size() && cyc < 20000) begin
            v   = pix[idx];
            vld = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sel == 0) begin
                a_in_valid = vld;
                a_in_data  = 9'(v);
                if (rand_ready) a_out_ready = ($urandom_range(0, 1) == 1);
            end else begin
                b_in_valid = vld;
                b_in_data  = 9'(v);
                if (rand_ready) b_out_ready = ($urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            acc = (sel == 0) ? (a_in_valid && a_in_ready) : (b_in_valid && b_in_ready);
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        checks++;
        if (idx != pix.size()) begin
            failures++;
            $display("[TB] FAIL drive_budget sel=%0d accepted=%0d required=%0d", sel, idx, pix.size());
        end
    endtask

    task automatic test_reset();
        a_rst = 1'b1; b_rst = 1'b1;
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        a_in_data = '0; b_in_data = '0;
        a_out_ready = 1'b0; b_out_ready = 1'b0;
        wait_cycles(3);
        a_rst = 1'b0; b_rst = 1'b0;
        wait_cycles(1);
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b want=0", a_out_valid); end
        checks++;
        if (a_out_data !== 9'sd0) begin failures++; $display("[TB] FAIL reset_out_data got=%0d want=0", a_out_data); end
        checks++;
        if (a_out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last got=%b want=0", a_out_last); end
        checks++;
        if (a_in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b want=1", a_in_ready); end
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_b got_valid=%b got_ready=%b want 0/1", b_out_valid, b_in_ready);
        end
    endtask

    task automatic test_ramp();
        int pix[$];
        for (int i = 0; i < 16; i++) pix.push_back(i);
        a_got_d.delete(); a_got_l.delete(); exp_d.delete(); exp_l.delete();
        build_expected(pix, 4, 4, 0);
        a_out_ready = 1'b1;
        drive_frame(0, pix, 1'b0, 1'b0);
        wait_cycles(6);
        checks++;
        if (a_got_d.size() != exp_d.size()) begin
            failures++; $display("[TB] FAIL ramp_count got=%0d want=%0d", a_got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < a_got_d.size(); i++) begin
            checks++;
            if (a_got_d[i] != exp_d[i]) begin failures++; $display("[TB] FAIL ramp_data[%0d] got=%0d want=%0d", i, a_got_d[i], exp_d[i]); end
            checks++;
            if (a_got_l[i] != exp_l[i]) begin failures++; $display("[TB] FAIL ramp_last[%0d] got=%b want=%b", i, a_got_l[i], exp_l[i]); end
        end
    endtask

    // Directed top-left window inside an otherwise random frame; sel_case 0 = negatives, 1 = extremes.
    task automatic test_windows(input int sel_case);
        int pix[$];
        int got0;
        int got1;
        int want0;
        int want1;
        for (int i = 0; i < 16; i++) pix.push_back(int'($urandom_range(0, 511)) - 256);
        if (sel_case == 0) begin
            pix[0] = -3; pix[1] = -7; pix[4] = -1; pix[5] = -9;
            want0 = NEG_EXP;
            want1 = -100000;
        end else begin
            pix[0] = 255; pix[1] = -256; pix[4] = 255; pix[5] = -256;
            pix[2] = -256; pix[3] = -256; pix[6] = -256; pix[7] = -256;
            want0 = 255;
            want1 = MIN_EXP;
        end
        a_got_d.delete(); a_got_l.delete(); exp_d.delete(); exp_l.delete();
        build_expected(pix, 4, 4, 0);
        a_out_ready = 1'b1;
        drive_frame(0, pix, 1'b1, 1'b1);
        a_out_ready = 1'b1;
        wait_cycles(6);
        got0 = (a_got_d.size() > 0) ? a_got_d[0] : 9999;
        got1 = (a_got_d.size() > 1) ? a_got_d[1] : 9999;
        checks++;
        if (got0 != want0) begin failures++; $display("[TB] FAIL window%0d_first got=%0d want=%0d", sel_case, got0, want0); end
        if (sel_case == 1) begin
            checks++;
            if (got1 != want1) begin failures++; $display("[TB] FAIL all_min_window got=%0d want=%0d", got1, want1); end
        end
        checks++;
        if (a_got_d.size() != exp_d.size()) begin
            failures++; $display("[TB] FAIL window%0d_count got=%0d want=%0d", sel_case, a_got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < a_got_d.size(); i++) begin
            checks++;
            if (a_got_d[i] != exp_d[i] || a_got_l[i] != exp_l[i]) begin
                failures++;
                $display("[TB] FAIL window%0d_out[%0d] got=%0d/%b want=%0d/%b", sel_case, i, a_got_d[i], a_got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int pix[$];
        int hold;
        bit found;
        for (int i = 0; i < 16; i++) pix.push_back(i);
        a_got_d.delete(); a_got_l.delete(); exp_d.delete(); exp_l.delete();
        build_expected(pix, 4, 4, 0);
        a_out_ready = 1'b1;
        found = 1'b0;
        hold = 0;
        fork
            drive_frame(0, pix, 1'b0, 1'b0);
            begin
                for (int c = 0; c < 40 && !found; c++) begin
                    @(posedge clk);
                    #1;
                    if (a_out_valid) found = 1'b1;
                end
                checks++;
                if (!found) begin
                    failures++; $display("[TB] FAIL bp_wait_valid got=0 want=1");
                end else begin
                    a_out_ready = 1'b0;
                    hold = int'(a_out_data);
                    checks++;
                    if (hold != 5) begin failures++; $display("[TB] FAIL bp_first_value got=%0d want=5", hold); end
                    for (int k = 0; k < 5; k++) begin
                        @(negedge clk);
                        checks++;
                        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || int'(a_out_data) != hold) begin
                            failures++;
                            $display("[TB] FAIL bp_hold[%0d] got ready=%b valid=%b data=%0d want 0/1/%0d", k, a_in_ready, a_out_valid, a_out_data, hold);
                        end
                        @(posedge clk);
                        #1;
                    end
                    a_out_ready = 1'b1;
                end
            end
        join
        wait_cycles(6);
        checks++;
        if (a_got_d.size() != exp_d.size()) begin
            failures++; $display("[TB] FAIL bp_count got=%0d want=%0d", a_got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < a_got_d.size(); i++) begin
            checks++;
            if (a_got_d[i] != exp_d[i] || a_got_l[i] != exp_l[i]) begin
                failures++;
                $display("[TB] FAIL bp_out[%0d] got=%0d/%b want=%0d/%b", i, a_got_d[i], a_got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int ramp[$];
        int part[$];
        for (int i = 0; i < 16; i++) ramp.push_back(i);
        for (int i = 0; i < 7; i++) part.push_back(i);
        a_got_d.delete(); a_got_l.delete();
        a_out_ready = 1'b1;
        drive_frame(0, part, 1'b0, 1'b0);
        checks++;
        if (a_got_d.size() != 1 || (a_got_d.size() > 0 && a_got_d[0] != 5)) begin
            failures++; $display("[TB] FAIL mid_partial got_count=%0d want one output of 5", a_got_d.size());
        end
        a_rst = 1'b1;
        wait_cycles(1);
        checks++;
        if (a_out_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_valid got=%b want=0", a_out_valid); end
        a_rst = 1'b0;

        // Leave the first window pending under back-pressure, then reset over it.
        part.delete();
        for (int i = 0; i < 6; i++) part.push_back(i);
        a_out_ready = 1'b0;
        drive_frame(0, part, 1'b0, 1'b0);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 9'sd5) begin
            failures++; $display("[TB] FAIL mid_pending got valid=%b data=%0d want 1/5", a_out_valid, a_out_data);
        end
        a_rst = 1'b1;
        wait_cycles(1);
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 9'sd0 || a_out_last !== 1'b0) begin
            failures++; $display("[TB] FAIL mid_drop got valid=%b data=%0d last=%b want 0/0/0", a_out_valid, a_out_data, a_out_last);
        end
        a_rst = 1'b0;

        a_got_d.delete(); a_got_l.delete(); exp_d.delete(); exp_l.delete();
        build_expected(ramp, 4, 4, 0);
        a_out_ready = 1'b1;
        drive_frame(0, ramp, 1'b0, 1'b0);
        wait_cycles(6);
        checks++;
        if (a_got_d.size() != exp_d.size()) begin
            failures++; $display("[TB] FAIL mid_fresh_count got=%0d want=%0d", a_got_d.size(), exp_d.size());
        end
        for (int i = 0; i < exp_d.size() && i < a_got_d.size(); i++) begin
            checks++;
            if (a_got_d[i] != exp_d[i] || a_got_l[i] != exp_l[i]) begin
                failures++;
                $display("[TB] FAIL mid_fresh[%0d] got=%0d/%b want=%0d/%b", i, a_got_d[i], a_got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pix[$];
        int lasts;
        int bad;
        for (int i = 0; i < 2 * 26 * 26; i++) pix.push_back(int'($urandom_range(0, 511)) - 256);
        b_got_d.delete(); b_got_l.delete(); exp_d.delete(); exp_l.delete();
        build_expected(pix, 26, 26, 0);
        build_expected(pix, 26, 26, 26 * 26);
        b_out_ready = 1'b1;
        drive_frame(1, pix, 1'b1, 1'b1);
        b_out_ready = 1'b1;
        wait_cycles(10);
        checks++;
        if (b_got_d.size() != 338) begin
            failures++; $display("[TB] FAIL b2b_count got=%0d want=338", b_got_d.size());
        end
        lasts = 0;
        foreach (b_got_l[i]) if (b_got_l[i]) lasts++;
        checks++;
        if (lasts != 2) begin failures++; $display("[TB] FAIL b2b_last_count got=%0d want=2", lasts); end
        bad = 0;
        for (int i = 0; i < exp_d.size() && i < b_got_d.size(); i++) begin
            checks++;
            if (b_got_d[i] != exp_d[i] || b_got_l[i] != exp_l[i]) begin
                failures++;
                bad++;
                if (bad <= 10) $display("[TB] FAIL b2b_out[%0d] got=%0d/%b want=%0d/%b", i, b_got_d[i], b_got_l[i], exp_d[i], exp_l[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_windows(0);
        test_windows(1);
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
